// File: rtl/axi4_lite_arbiter.sv
// Two-master AXI4-Lite arbiter: IFU (read-only) and LSU (read/write) share one downstream port.
// Define ARB_ROUND_ROBIN_EN to alternate IFU/LSU on conflicts; the default build uses fixed priority (LSU wr > LSU rd > IFU).
module axi4_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    output logic [1:0]            lsu_bresp,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready
);

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;

    state_e state_q, state_d, grant;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   ifu_req, lsu_wr_req, lsu_rd_req;

    assign ifu_req    = ifu_arvalid;
    assign lsu_wr_req = lsu_awvalid | lsu_wvalid;
    assign lsu_rd_req = lsu_arvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ifu_q, last_ifu_d;

    // IFU takes a conflict only when the previous grant went to the LSU
    always_comb begin
        grant = IDLE;
        if (ifu_req && !last_ifu_q) grant = IFU_RD;
        else if (lsu_wr_req)        grant = LSU_WR;
        else if (lsu_rd_req)        grant = LSU_RD;
        else if (ifu_req)           grant = IFU_RD;
    end

    always_comb begin
        last_ifu_d = last_ifu_q;
        if (state_q == IDLE && grant != IDLE) last_ifu_d = (grant == IFU_RD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_ifu_q <= 1'b0;
        else     last_ifu_q <= last_ifu_d;
    end
`else
    always_comb begin
        grant = IDLE;
        if (lsu_wr_req)      grant = LSU_WR;
        else if (lsu_rd_req) grant = LSU_RD;
        else if (ifu_req)    grant = IFU_RD;
    end
`endif

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE:           state_d = grant;
            IFU_RD, LSU_RD: if (s_rvalid && s_rready) state_d = IDLE;
            LSU_WR: begin
                if (s_awvalid && s_awready) aw_done_d = 1'b1;
                if (s_wvalid && s_wready)   w_done_d  = 1'b1;
                if (s_bvalid && s_bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default:        state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Payloads fan out unconditionally; only the handshake signals are steered by the grant
    assign ifu_rdata = s_rdata;
    assign ifu_rresp = s_rresp;
    assign lsu_rdata = s_rdata;
    assign lsu_rresp = s_rresp;
    assign lsu_bresp = s_bresp;
    assign s_awaddr  = lsu_awaddr;
    assign s_wdata   = lsu_wdata;
    assign s_wstrb   = lsu_wstrb;

    always_comb begin
        s_araddr    = lsu_araddr;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        case (state_q)
            IFU_RD: begin
                s_araddr    = ifu_araddr;
                s_arvalid   = ifu_arvalid;
                ifu_arready = s_arready;
                ifu_rvalid  = s_rvalid;
                s_rready    = ifu_rready;
            end
            LSU_RD: begin
                s_arvalid   = lsu_arvalid;
                lsu_arready = s_arready;
                lsu_rvalid  = s_rvalid;
                s_rready    = lsu_rready;
            end
            LSU_WR: begin
                // A completed AW or W channel is masked so it is never issued twice
                s_awvalid   = lsu_awvalid & ~aw_done_q;
                lsu_awready = s_awready & ~aw_done_q;
                s_wvalid    = lsu_wvalid & ~w_done_q;
                lsu_wready  = s_wready & ~w_done_q;
                lsu_bvalid  = s_bvalid & aw_done_q & w_done_q;
                s_bready    = lsu_bready & aw_done_q & w_done_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Self-checking bench for axi4_lite_arbiter: directed scenarios plus randomized request episodes
// checked against a transaction-level model (memory image, service-order prediction).
module tb_axi4_lite_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef enum int {T_IFU, T_LRD, T_LWR} tag_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0, s_rdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic ifu_arvalid = 0, ifu_rready = 0, lsu_arvalid = 0, lsu_rready = 0;
    logic lsu_awvalid = 0, lsu_wvalid = 0, lsu_bready = 0;
    logic s_arready = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
    logic [1:0] s_rresp = '0, s_bresp = '0;
    logic ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
    logic [31:0] ifu_rdata, lsu_rdata, s_araddr, s_awaddr, s_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
    logic [3:0]  s_wstrb;
    logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

    axi4_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Downstream handshake counters and the arbitration history seen from completed transactions
    int n_aw_hs = 0;
    int n_w_hs  = 0;
    bit last_ifu_m = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ifu_m <= 1'b0;
        end else begin
            if (s_awvalid && s_awready) n_aw_hs <= n_aw_hs + 1;
            if (s_wvalid && s_wready)   n_w_hs  <= n_w_hs + 1;
            if (ifu_rvalid && ifu_rready) last_ifu_m <= 1'b1;
            else if ((lsu_rvalid && lsu_rready) || (lsu_bvalid && lsu_bready)) last_ifu_m <= 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] all_hs_outs();
        return {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, ifu_arready,
                lsu_arready, lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid, lsu_bvalid};
    endfunction

    task automatic clear_inputs();
        ifu_arvalid = 0; ifu_rready = 0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_wvalid = 0; lsu_bready = 0;
        s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
        s_rresp = 0; s_bresp = 0;
    endtask

    // ---------------- reference memory and downstream slave memory ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic logic [31:0] rd_slv(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    // ---------------- random-episode engine state ----------------
    bit ifu_pend, ifu_sent, lrd_pend, lrd_sent, lwr_pend, aw_sent, w_sent;
    int aw_dly, w_dly;
    logic [31:0] ifu_a, lrd_a, lwr_a, lwr_d;
    logic [3:0]  lwr_s;
    bit rd_out, aw_got, w_got;
    int r_wait, b_wait;
    logic [31:0] s_ra, s_wa, s_wd;
    logic [3:0]  s_ws;
    int gap_ph;
    tag_e exp_q[$];
    tag_e act_q[$];

    // Entered at posedge+1 with inputs applied; samples at the falling edge, then advances one cycle
    task automatic run_cycle();
        bit ifu_ar, lrd_ar, aw_m, w_m, ifu_r, lrd_r, lb, sar, sr, saw, sw, sb;
        logic [31:0] ar_a, w_d;
        logic [3:0]  w_s;
        #4;
        ifu_ar = ifu_arvalid && ifu_arready;  lrd_ar = lsu_arvalid && lsu_arready;
        aw_m   = lsu_awvalid && lsu_awready;  w_m    = lsu_wvalid && lsu_wready;
        ifu_r  = ifu_rvalid && ifu_rready;    lrd_r  = lsu_rvalid && lsu_rready;
        lb     = lsu_bvalid && lsu_bready;
        sar = s_arvalid && s_arready;  sr = s_rvalid && s_rready;
        saw = s_awvalid && s_awready;  sw = s_wvalid && s_wready;  sb = s_bvalid && s_bready;
        ar_a = s_araddr;  w_d = s_wdata;  w_s = s_wstrb;

        if (gap_ph == 1) begin
            check("idle_no_valid", {s_arvalid, s_awvalid, s_wvalid}, 0);
            gap_ph = (ifu_arvalid || lsu_arvalid || lsu_awvalid || lsu_wvalid) ? 2 : 0;
        end else if (gap_ph == 2) begin
            check("grant_latency", s_arvalid | s_awvalid | s_wvalid, 1);
            gap_ph = 0;
        end
        if (sar) check("ar_exclusive", rd_out | aw_got | w_got, 0);
        if (saw) check("aw_exclusive", rd_out | aw_got, 0);
        if (sw)  check("w_exclusive", rd_out | w_got, 0);
        if (saw) check("aw_payload", s_awaddr, lwr_a);
        if (sw)  check("w_payload", {w_s, w_d}, {lwr_s, lwr_d});
        if (ifu_rvalid) check("ifu_rvalid_owner", ifu_pend & ifu_sent, 1);
        if (lsu_rvalid) check("lsu_rvalid_owner", lrd_pend & lrd_sent, 1);
        if (lsu_bvalid) check("lsu_bvalid_owner", lwr_pend & aw_sent & w_sent, 1);
        if (ifu_r) begin
            check("ifu_rdata", ifu_rdata, rd_ref(ifu_a));
            check("ifu_rresp", ifu_rresp, ifu_a[3:2]);
            act_q.push_back(T_IFU); ifu_pend = 0; gap_ph = 1;
        end
        if (lrd_r) begin
            check("lsu_rdata", lsu_rdata, rd_ref(lrd_a));
            check("lsu_rresp", lsu_rresp, lrd_a[3:2]);
            act_q.push_back(T_LRD); lrd_pend = 0; gap_ph = 1;
        end
        if (lb) begin
            check("lsu_bresp", lsu_bresp, lwr_a[3:2]);
            ref_mem[lwr_a] = merge(rd_ref(lwr_a), lwr_d, lwr_s);
            act_q.push_back(T_LWR); lwr_pend = 0; gap_ph = 1;
        end

        step();
        // masters: drop valid after handshake, raise delayed write channels
        if (ifu_ar) begin ifu_arvalid = 0; ifu_sent = 1; end
        if (lrd_ar) begin lsu_arvalid = 0; lrd_sent = 1; end
        if (aw_m)   begin lsu_awvalid = 0; aw_sent = 1; end
        if (w_m)    begin lsu_wvalid = 0; w_sent = 1; end
        if (lwr_pend && !aw_sent && !lsu_awvalid) begin
            if (aw_dly == 0) lsu_awvalid = 1; else aw_dly--;
        end
        if (lwr_pend && !w_sent && !lsu_wvalid) begin
            if (w_dly == 0) lsu_wvalid = 1; else w_dly--;
        end
        ifu_rready = 1'($urandom_range(0, 1));
        lsu_rready = 1'($urandom_range(0, 1));
        lsu_bready = 1'($urandom_range(0, 1));
        // downstream slave with random readiness and latency
        s_arready = 1'($urandom_range(0, 1));
        s_awready = 1'($urandom_range(0, 1));
        s_wready  = 1'($urandom_range(0, 1));
        if (sar) begin rd_out = 1; s_ra = ar_a; r_wait = $urandom_range(0, 2); end
        if (sr) begin
            s_rvalid = 0; rd_out = 0;
        end else if (rd_out && !s_rvalid) begin
            if (r_wait == 0) begin s_rvalid = 1; s_rdata = rd_slv(s_ra); s_rresp = s_ra[3:2]; end
            else r_wait--;
        end
        if (saw) begin aw_got = 1; s_wa = s_awaddr; b_wait = $urandom_range(0, 2); end
        if (sw)  begin w_got = 1; s_wd = w_d; s_ws = w_s; b_wait = $urandom_range(0, 2); end
        if (sb) begin
            s_bvalid = 0; aw_got = 0; w_got = 0;
        end else if (aw_got && w_got && !s_bvalid) begin
            if (b_wait == 0) begin
                s_bvalid = 1; s_bresp = s_wa[3:2];
                slv_mem[s_wa] = merge(rd_slv(s_wa), s_wd, s_ws);
            end else b_wait--;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h1000_0000 + (32'($urandom_range(0, 7)) << 2);
    endfunction

    task automatic episode(input bit do_i, input bit do_r, input bit do_w);
        bit pi, pr, pw, li;
        tag_e pick;
        pi = do_i; pr = do_r; pw = do_w; li = last_ifu_m;
        exp_q.delete(); act_q.delete();
        // expected service order from the arbitration rules applied to the pending set
        while (pi || pr || pw) begin
            if (RR && pi && !li) pick = T_IFU;
            else if (pw)         pick = T_LWR;
            else if (pr)         pick = T_LRD;
            else                 pick = T_IFU;
            exp_q.push_back(pick);
            if (pick == T_IFU) pi = 0; else if (pick == T_LRD) pr = 0; else pw = 0;
            li = (pick == T_IFU);
        end
        if (do_i) begin
            ifu_pend = 1; ifu_sent = 0; ifu_a = rand_addr(); ifu_araddr = ifu_a; ifu_arvalid = 1;
        end
        if (do_r) begin
            lrd_pend = 1; lrd_sent = 0; lrd_a = rand_addr(); lsu_araddr = lrd_a; lsu_arvalid = 1;
        end
        if (do_w) begin
            lwr_pend = 1; aw_sent = 0; w_sent = 0;
            lwr_a = rand_addr(); lwr_d = $urandom; lwr_s = 4'($urandom_range(1, 15));
            lsu_awaddr = lwr_a; lsu_wdata = lwr_d; lsu_wstrb = lwr_s;
            if ($urandom_range(0, 1) == 1) begin lsu_awvalid = 1; w_dly = $urandom_range(0, 3); end
            else begin lsu_wvalid = 1; aw_dly = $urandom_range(0, 3); end
        end
        gap_ph = 1;
        for (int c = 0; c < 400 && (ifu_pend || lrd_pend || lwr_pend); c++) run_cycle();
        check("episode_complete", {ifu_pend, lrd_pend, lwr_pend}, 0);
        check("order_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) check("service_order", act_q[i], exp_q[i]);
        run_cycle();
        run_cycle();
    endtask

    initial begin
        int base_aw, base_w;
        bit [2:0] sel;

        // ---- reset: outputs stay quiet even with requests pending ----
        ifu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1; s_arready = 1; s_awready = 1; s_wready = 1;
        step(); step();
        #4; check("reset_outputs", all_hs_outs(), 0);
        step(); clear_inputs(); rst = 0;
        step();

        // ---- IFU read alone ----
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
        #4; check("ifu_rd_idle_arvalid", s_arvalid, 0);
        step(); s_arready = 1;
        #4; check("ifu_rd_arvalid", s_arvalid, 1);
            check("ifu_rd_araddr", s_araddr, 32'h8000_0000);
            check("ifu_rd_arready", ifu_arready, 1);
        step(); ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_0413; ifu_rready = 1;
        #4; check("ifu_rd_rvalid", ifu_rvalid, 1);
            check("ifu_rd_rdata", ifu_rdata, 32'h0000_0413);
            check("ifu_rd_lsu_rvalid", lsu_rvalid, 0);
            check("ifu_rd_s_rready", s_rready, 1);
        step(); s_rvalid = 0; ifu_rready = 0; lsu_araddr = 32'h1000_0040; lsu_arvalid = 1; s_arready = 1;
        #4; check("ifu_rd_back_idle", {s_arvalid, lsu_arready, s_rready}, 0);
        step();
        #4; check("lsu_rd_grant", {s_arvalid, lsu_arready}, 2'b11);
            check("lsu_rd_araddr", s_araddr, 32'h1000_0040);
        step(); lsu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h1234_5678; lsu_rready = 1;
        #4; check("lsu_rd_rdata", {lsu_rvalid, lsu_rdata}, {1'b1, 32'h1234_5678});
            check("lsu_rd_ifu_rvalid", ifu_rvalid, 0);
        step(); clear_inputs();
        step();

        // ---- backpressure on IFU R with an LSU read waiting ----
        ifu_araddr = 32'h8000_0010; ifu_arvalid = 1; s_arready = 1;
        step();
        step(); ifu_arvalid = 0; s_arready = 1; lsu_arvalid = 1; lsu_araddr = 32'h1000_0020;
                s_rvalid = 1; s_rdata = 32'hCAFE_0001; ifu_rready = 0;
        for (int k = 0; k < 3; k++) begin
            #4; check("bp_s_rready", s_rready, 0);
                check("bp_ifu_rvalid", ifu_rvalid, 1);
                check("bp_lsu_arready", {lsu_arready, s_arvalid}, 0);
            step();
        end
        ifu_rready = 1;
        #4; check("bp_release", {s_rready, ifu_rvalid}, 2'b11);
        step(); s_rvalid = 0; ifu_rready = 0;
        #4; check("bp_idle_gap", {lsu_arready, s_arvalid}, 0);
        step();
        #4; check("bp_lsu_granted", {lsu_arready, s_arvalid}, 2'b11);
        step(); lsu_arvalid = 0; s_rvalid = 1; s_rdata = 32'hCAFE_0002; lsu_rready = 1;
        #4; check("bp_lsu_rdata", {lsu_rvalid, lsu_rdata}, {1'b1, 32'hCAFE_0002});
        step(); clear_inputs();
        step();

        // ---- LSU write, W accepted one cycle before AW ----
        base_aw = n_aw_hs; base_w = n_w_hs;
        s_awready = 1; s_wready = 1; lsu_bready = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_awaddr = 32'ha000_03f8; lsu_wvalid = 1;
        #4; check("wr_idle_wvalid", s_wvalid, 0);
        step();
        #4; check("wr_w_fwd", {s_wvalid, lsu_wready, s_awvalid}, 3'b110);
            check("wr_w_data", {s_wstrb, s_wdata}, {4'hF, 32'hDEAD_BEEF});
        step(); lsu_wvalid = 0; lsu_awvalid = 1;
        #4; check("wr_aw_fwd", {s_awvalid, lsu_awready, s_wvalid, lsu_bvalid}, 4'b1100);
            check("wr_aw_addr", s_awaddr, 32'ha000_03f8);
        step(); lsu_awvalid = 0; s_bvalid = 1; s_bresp = 2'b10;
        #4; check("wr_b_fwd", {lsu_bvalid, s_bready, s_wvalid, s_awvalid}, 4'b1100);
            check("wr_bresp", lsu_bresp, 2'b10);
        step(); clear_inputs();
        #4; check("wr_hs_counts", {n_aw_hs - base_aw, n_w_hs - base_w}, {32'd1, 32'd1});
        step();

        // ---- reset in the middle of a write (after AW, before W) ----
        lsu_awaddr = 32'ha000_0100; lsu_awvalid = 1; s_awready = 1;
        step();
        #4; check("rst_wr_aw", {s_awvalid, lsu_awready}, 2'b11);
        step(); lsu_awvalid = 0; lsu_wvalid = 1; lsu_wdata = 32'h5555_AAAA; s_wready = 0;
        #4; check("rst_wr_wait_w", {s_awvalid, s_wvalid}, 2'b01);
        #1; rst = 1;
        #1; check("rst_wr_outputs", all_hs_outs(), 0);
        step(); rst = 0; clear_inputs();
        step();
        base_aw = n_aw_hs;
        lsu_awaddr = 32'ha000_0104; lsu_awvalid = 1; lsu_wvalid = 1; s_awready = 1; s_wready = 1; lsu_bready = 1;
        step();
        #4; check("rst_wr_aw_reissue", {s_awvalid, s_wvalid}, 2'b11);
        step(); lsu_awvalid = 0; lsu_wvalid = 0; s_bvalid = 1;
        #4; check("rst_wr_b", lsu_bvalid, 1);
        step(); clear_inputs();
        #4; check("rst_wr_aw_count", n_aw_hs - base_aw, 1);
        step(); step();

        // ---- randomized episodes: three IFU+LSU read conflicts, then random mixes ----
        ifu_pend = 0; lrd_pend = 0; lwr_pend = 0; rd_out = 0; aw_got = 0; w_got = 0; gap_ph = 0;
        for (int e = 0; e < 3; e++) episode(1'b1, 1'b1, 1'b0);
        for (int e = 0; e < 40; e++) begin
            sel = 3'($urandom_range(1, 7));
            episode(sel[0], sel[1], sel[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_arbiter.md
# axi4_lite_arbiter

Two-master AXI4-Lite arbiter sitting between the core's memory requesters and the address-decoding crossbar. The instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) each present an AXI4-Lite master port. The arbiter grants exactly one transaction at a time to the single downstream master port that feeds the crossbar. A grant is held from address handshake through response handshake, so the crossbar's registered read-response steering always sees one outstanding transaction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe width DATA_W/8)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_araddr/ifu_arvalid in ADDR_W/1; ifu_arready out 1  IFU read address
- ifu_rdata/ifu_rresp/ifu_rvalid out DATA_W/2/1; ifu_rready in 1  IFU read data
- lsu_araddr/lsu_arvalid in ADDR_W/1; lsu_arready out 1  LSU read address
- lsu_rdata/lsu_rresp/lsu_rvalid out DATA_W/2/1; lsu_rready in 1  LSU read data
- lsu_awaddr/lsu_awvalid in ADDR_W/1; lsu_awready out 1  LSU write address
- lsu_wdata/lsu_wstrb/lsu_wvalid in DATA_W/DATA_W/8/1; lsu_wready out 1  LSU write data
- lsu_bresp/lsu_bvalid out 2/1; lsu_bready in 1  LSU write response
- s_araddr/s_arvalid out ADDR_W/1; s_arready in 1  downstream read address
- s_rdata/s_rresp/s_rvalid in DATA_W/2/1; s_rready out 1  downstream read data
- s_awaddr/s_awvalid out ADDR_W/1; s_awready in 1  downstream write address
- s_wdata/s_wstrb/s_wvalid out DATA_W/DATA_W/8/1; s_wready in 1  downstream write data
- s_bresp/s_bvalid in 2/1; s_bready out 1  downstream write response

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR (registered). Auxiliary regs: aw_done, w_done, last_ifu.
- IDLE: all s_*valid, s_rready, s_bready, and all master-side ready/valid outputs are 0. Requests: ifu_req = ifu_arvalid; lsu_wr_req = lsu_awvalid | lsu_wvalid; lsu_rd_req = lsu_arvalid.
- IDLE grant (fixed priority build): lsu_wr_req -> LSU_WR, else lsu_rd_req -> LSU_RD, else ifu_req -> IFU_RD. Within the LSU, write always beats read.
- IFU_RD / LSU_RD: granted master's AR and R signals pass combinationally to and from s_*. The other master sees arready=0 and rvalid=0. Leave for IDLE on s_rvalid & s_rready.
- LSU_WR: s_awvalid = lsu_awvalid & ~aw_done; s_wvalid = lsu_wvalid & ~w_done. lsu_awready/lsu_wready are gated the same way. Set aw_done on an AW handshake and w_done on a W handshake; AW and W may complete in either order or in the same cycle. B is forwarded once both are done. On s_bvalid & s_bready, go to IDLE and clear aw_done and w_done.
- Address/data/strobe outputs are muxed from the granted master. In IDLE they carry the LSU values; they are don't-care while their valid is 0.
- last_ifu is updated on entry to a grant state (1 if IFU_RD).
- Masters hold valid and payload stable until handshake, per the AXI rule; the arbiter never drops a granted request.

## Timing
- Reset: state=IDLE, aw_done=w_done=0, last_ifu=0; all valid/ready outputs 0.
- Arbitration latency: a request first visible in IDLE at cycle N enters the grant state at N+1. Downstream valid is asserted in cycle N+1.
- Return to IDLE occurs the cycle after the final R/B handshake. The minimum gap between consecutive grants is therefore 1 IDLE cycle.
- Simultaneous requests in IDLE resolve by the priority rule; the loser waits with its ready held at 0.
- Asynchronous reset mid-transaction: returns to IDLE immediately; all valids drop to 0 in the same cycle. The in-flight transaction is abandoned; downstream is reset by the same rst.

## Configuration
- ARB_ROUND_ROBIN_EN defined: in IDLE, when ifu_req and an LSU request coexist, the IFU wins if last_ifu=0 and the LSU wins if last_ifu=1. LSU write still beats LSU read. After reset, the IFU wins the first conflict.
- Not defined: the fixed priority above applies (LSU write > LSU read > IFU); last_ifu is unused.

## Test plan
- IFU read alone: ifu_araddr=0x80000000 at cycle 1; slave arready=1 at cycle 2, rvalid=1 with rdata=0x00000413 at cycle 3 -> ifu_rdata=0x00000413 and ifu_rvalid=1 at cycle 3; state back to IDLE at cycle 4; lsu_rvalid stays 0 throughout.
- LSU write with W before AW: lsu_wvalid (wdata=0xDEADBEEF, wstrb=0xF) accepted one cycle before lsu_awvalid (awaddr=0xa00003f8) -> exactly one s_wvalid handshake and one s_awvalid handshake; lsu_bvalid follows s_bvalid; no repeat of W.
- Conflict, fixed build: ifu_arvalid and lsu_arvalid both rise at cycle 1 -> LSU granted at cycle 2; IFU granted at the cycle after the LSU R handshake plus one IDLE cycle.
- Conflict, ARB_ROUND_ROBIN_EN build: three consecutive simultaneous IFU+LSU read pairs -> grant order IFU, LSU, IFU, LSU, IFU, LSU.
- Backpressure: s_rvalid=1 with ifu_rready=0 for 3 cycles -> state stays IFU_RD and s_rready=0 for those 3 cycles; LSU arready=0 for the same cycles.
- Reset mid-write: assert rst after AW handshake, before W -> all outputs 0 in the same cycle; after release, a new LSU write issues AW again.
